// File: rtl/apb_arbiter.sv
// N-requester APB master front end: arbitrates one transfer at a time and runs
// the APB SETUP/ACCESS handshake with an optional PREADY timeout.
module apb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                           I_PCLK,
  input  logic                           I_PRESET,
  input  logic [NUM_REQ-1:0]             I_REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  I_REQ_ADDR,
  input  logic [NUM_REQ-1:0]             I_REQ_WRITE,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  I_REQ_WDATA,
  output logic [NUM_REQ-1:0]             O_GNT,
  output logic [NUM_REQ-1:0]             O_DONE,
  output logic [DATA_WIDTH-1:0]          O_RDATA,
  output logic                           O_ERR,
  output logic                           O_PSEL,
  output logic                           O_PENABLE,
  output logic                           O_PWRITE,
  output logic [ADDR_WIDTH-1:0]          O_PADDR,
  output logic [DATA_WIDTH-1:0]          O_PWDATA,
  input  logic                           I_PREADY,
  input  logic                           I_PSLVERR,
  input  logic [DATA_WIDTH-1:0]          I_PRDATA
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         w_win;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_pwrite;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [CW-1:0]         r_wait;
  logic                  w_timeout;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = I_REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata[gi] = I_REQ_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Walk the search order backwards so the earliest active candidate wins.
  always_comb begin : arb
    logic [IW-1:0] idx;
    idx   = '0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        idx = IW'((int'(r_last) + 1 + k) % NUM_REQ);
      end else begin
        idx = IW'(k);
      end
      if (I_REQ[idx]) begin
        w_win = idx;
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && !I_PREADY && (r_wait == TO_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (|I_REQ) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (I_PREADY || w_timeout) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_PCLK or posedge I_PRESET) begin
    if (I_PRESET) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NUM_REQ - 1);
      r_gnt    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_wait   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (|I_REQ) begin
            r_gnt    <= NUM_REQ'(1) << w_win;
            r_last   <= w_win;
            r_paddr  <= w_addr[w_win];
            r_pwrite <= I_REQ_WRITE[w_win];
            r_pwdata <= w_wdata[w_win];
          end
        end
        S_SETUP: r_wait <= '0;
        S_ACCESS: begin
          // A ready response wins over a timeout landing in the same cycle.
          if (I_PREADY) begin
            r_err   <= I_PSLVERR;
            r_rdata <= r_pwrite ? '0 : I_PRDATA;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
        end
        S_DONE: r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

  assign O_GNT     = r_gnt;
  assign O_DONE    = (r_state == S_DONE) ? r_gnt : '0;
  assign O_RDATA   = r_rdata;
  assign O_ERR     = r_err;
  assign O_PSEL    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign O_PENABLE = (r_state == S_ACCESS);
  assign O_PWRITE  = r_pwrite;
  assign O_PADDR   = r_paddr;
  assign O_PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: a round-robin and a fixed-priority instance run in
// lockstep on shared inputs, checked per cycle against transaction expectations.
module tb_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk;
  logic rst;
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] wdata_bus;
  logic [AW-1:0]   tb_addr  [N];
  logic [DW-1:0]   tb_wdata [N];
  logic            pready;
  logic            pslverr;
  logic [DW-1:0]   prdata;

  logic [N-1:0]  gnt    [2];
  logic [N-1:0]  done   [2];
  logic [DW-1:0] rdata  [2];
  logic          err    [2];
  logic          psel   [2];
  logic          pen    [2];
  logic          pwrite [2];
  logic [AW-1:0] paddr  [2];
  logic [DW-1:0] pwdata [2];

  int checks   = 0;
  int failures = 0;
  int lg_rr    = N - 1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign addr_bus[gi*AW +: AW]  = tb_addr[gi];
      assign wdata_bus[gi*DW +: DW] = tb_wdata[gi];
    end
  endgenerate

  apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(TO)) dut_rr (
    .I_PCLK(clk), .I_PRESET(rst), .I_REQ(req), .I_REQ_ADDR(addr_bus), .I_REQ_WRITE(wr),
    .I_REQ_WDATA(wdata_bus), .O_GNT(gnt[0]), .O_DONE(done[0]), .O_RDATA(rdata[0]), .O_ERR(err[0]),
    .O_PSEL(psel[0]), .O_PENABLE(pen[0]), .O_PWRITE(pwrite[0]), .O_PADDR(paddr[0]),
    .O_PWDATA(pwdata[0]), .I_PREADY(pready), .I_PSLVERR(pslverr), .I_PRDATA(prdata));

  apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(TO)) dut_fp (
    .I_PCLK(clk), .I_PRESET(rst), .I_REQ(req), .I_REQ_ADDR(addr_bus), .I_REQ_WRITE(wr),
    .I_REQ_WDATA(wdata_bus), .O_GNT(gnt[1]), .O_DONE(done[1]), .O_RDATA(rdata[1]), .O_ERR(err[1]),
    .O_PSEL(psel[1]), .O_PENABLE(pen[1]), .O_PWRITE(pwrite[1]), .O_PADDR(paddr[1]),
    .O_PWDATA(pwdata[1]), .I_PREADY(pready), .I_PSLVERR(pslverr), .I_PRDATA(prdata));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int fp_pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_idle(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_psel"}, d, 64'(psel[d]), 64'(0));
      chk({nm, "_penable"}, d, 64'(pen[d]), 64'(0));
      chk({nm, "_gnt"}, d, 64'(gnt[d]), 64'(0));
      chk({nm, "_done"}, d, 64'(done[d]), 64'(0));
    end
  endtask

  // Called just after a negedge in an IDLE cycle (cycle 0); returns just after
  // the negedge of the IDLE cycle that follows DONE.
  task automatic run_xfer(input logic [N-1:0] rq, input logic [N-1:0] wv, input int waits,
                          input logic slv, input logic [DW-1:0] rd, input int win_rr,
                          input int win_fp, input int dcyc, input logic e_err_rr,
                          input logic [DW-1:0] e_rd_rr, input logic e_err_fp,
                          input logic [DW-1:0] e_rd_fp, input bit scramble);
    logic [AW-1:0] xa [2];
    logic [DW-1:0] xd [2];
    logic          xw [2];
    logic [N-1:0]  xg [2];
    logic          xe [2];
    logic [DW-1:0] xr [2];
    int            win [2];
    win[0] = win_rr; win[1] = win_fp;
    xe[0]  = e_err_rr; xe[1] = e_err_fp;
    xr[0]  = e_rd_rr;  xr[1] = e_rd_fp;
    req = rq;
    wr  = wv;
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    for (int d = 0; d < 2; d++) begin
      xa[d] = tb_addr[win[d]];
      xd[d] = tb_wdata[win[d]];
      xw[d] = wv[win[d]];
      xg[d] = N'(1) << win[d];
    end
    for (int c = 1; c <= dcyc + 1; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic         ep;
        logic         een;
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        ep  = (c < dcyc);
        een = (c >= 2) && (c < dcyc);
        eg  = (c <= dcyc) ? xg[d] : '0;
        ed  = (c == dcyc) ? xg[d] : '0;
        chk("psel", d, 64'(psel[d]), 64'(ep));
        chk("penable", d, 64'(pen[d]), 64'(een));
        chk("gnt", d, 64'(gnt[d]), 64'(eg));
        chk("done", d, 64'(done[d]), 64'(ed));
        chk("paddr", d, 64'(paddr[d]), 64'(xa[d]));
        chk("pwrite", d, 64'(pwrite[d]), 64'(xw[d]));
        chk("pwdata", d, 64'(pwdata[d]), 64'(xd[d]));
        if (c == dcyc) begin
          chk("err", d, 64'(err[d]), 64'(xe[d]));
          chk("rdata", d, 64'(rdata[d]), 64'(xr[d]));
        end
      end
      if (scramble) begin
        req = N'($urandom);
        wr  = N'($urandom);
        for (int i = 0; i < N; i++) begin
          tb_addr[i]  = AW'($urandom);
          tb_wdata[i] = $urandom;
        end
      end
      if ((c >= 2) && (c < dcyc) && ((c - 2) >= waits)) begin
        pready  = 1'b1;
        pslverr = slv;
        prdata  = rd;
      end else begin
        pready  = ((c >= 2) && (c < dcyc)) ? 1'b0 : 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
    lg_rr = win_rr;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          wr;
    int            waits;
    logic          slv;
    logic [DW-1:0] prd;
    int            win_rr;
    int            win_fp;
    int            dcyc;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{4'b0001, 1'b1, 0,  1'b0, 32'h55555555, 0, 0, 3,  1'b0, 32'h0};
    tbl[1]  = '{4'b1111, 1'b1, 0,  1'b0, 32'h0,        1, 0, 3,  1'b0, 32'h0};
    tbl[2]  = '{4'b1111, 1'b1, 0,  1'b0, 32'h0,        2, 0, 3,  1'b0, 32'h0};
    tbl[3]  = '{4'b1111, 1'b1, 0,  1'b0, 32'h0,        3, 0, 3,  1'b0, 32'h0};
    tbl[4]  = '{4'b1111, 1'b1, 0,  1'b0, 32'h0,        0, 0, 3,  1'b0, 32'h0};
    tbl[5]  = '{4'b0001, 1'b0, 3,  1'b0, 32'h12345678, 0, 0, 6,  1'b0, 32'h12345678};
    tbl[6]  = '{4'b0010, 1'b0, 16, 1'b0, 32'hCAFEF00D, 1, 1, 18, 1'b1, 32'h0};
    tbl[7]  = '{4'b0100, 1'b0, 15, 1'b0, 32'hA5A5A5A5, 2, 2, 18, 1'b0, 32'hA5A5A5A5};
    tbl[8]  = '{4'b1000, 1'b1, 0,  1'b1, 32'h0,        3, 3, 3,  1'b1, 32'h0};
    tbl[9]  = '{4'b1010, 1'b1, 2,  1'b0, 32'h0,        1, 1, 5,  1'b0, 32'h0};
    tbl[10] = '{4'b0101, 1'b0, 1,  1'b1, 32'h0BADF00D, 2, 0, 4,  1'b1, 32'h0BADF00D};

    req = '0; wr = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int i = 0; i < N; i++) begin
      tb_addr[i]  = AW'(16'h0010 + i * 16'h0100);
      tb_wdata[i] = 32'hDEADBEEF + 32'(i);
    end

    // Reset must clear outputs before any clock edge.
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", d, 64'(gnt[d]), 64'(0));
      chk("rst_done", d, 64'(done[d]), 64'(0));
      chk("rst_psel", d, 64'(psel[d]), 64'(0));
      chk("rst_penable", d, 64'(pen[d]), 64'(0));
      chk("rst_paddr", d, 64'(paddr[d]), 64'(0));
      chk("rst_pwrite", d, 64'(pwrite[d]), 64'(0));
      chk("rst_pwdata", d, 64'(pwdata[d]), 64'(0));
      chk("rst_rdata", d, 64'(rdata[d]), 64'(0));
      chk("rst_err", d, 64'(err[d]), 64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 11; t++) begin
      run_xfer(tbl[t].req, {N{tbl[t].wr}}, tbl[t].waits, tbl[t].slv, tbl[t].prd,
               tbl[t].win_rr, tbl[t].win_fp, tbl[t].dcyc, tbl[t].err, tbl[t].rdata,
               tbl[t].err, tbl[t].rdata, 1'b0);
    end

    // Asynchronous reset between edges while in ACCESS.
    req = 4'b0100; wr = '0; pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("pre_rst_penable", d, 64'(pen[d]), 64'(1));
      chk("pre_rst_gnt", d, 64'(gnt[d]), 64'(4'b0100));
    end
    #2 rst = 1'b1;
    #1 check_idle("async_rst");
    @(posedge clk);
    #1 check_idle("in_rst");
    @(negedge clk);
    rst = 1'b0;
    lg_rr = N - 1;
    run_xfer(4'b1111, 4'b1111, 0, 1'b0, 32'h0, 0, 0, 3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the transaction-level model.
    for (int t = 0; t < 80; t++) begin
      logic [N-1:0]  rq;
      logic [N-1:0]  wv;
      int            waits;
      logic          slv;
      logic [DW-1:0] rd;
      int            w0;
      int            w1;
      bit            tmo;
      rq = N'($urandom);
      wv = N'($urandom);
      for (int i = 0; i < N; i++) begin
        tb_addr[i]  = AW'($urandom);
        tb_wdata[i] = $urandom;
      end
      waits = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 20));
      slv   = ($urandom_range(0, 3) == 0);
      rd    = $urandom;
      if (rq == '0) begin
        req = '0;
        pready = 1'($urandom);
        @(negedge clk);
        check_idle("no_req");
      end else begin
        w0  = rr_pick(rq, lg_rr);
        w1  = fp_pick(rq);
        tmo = (waits >= TO);
        run_xfer(rq, wv, waits, slv, rd, w0, w1, tmo ? TO + 2 : waits + 3,
                 tmo ? 1'b1 : slv, (tmo || wv[w0]) ? '0 : rd,
                 tmo ? 1'b1 : slv, (tmo || wv[w1]) ? '0 : rd, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
